// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : layer_compositor
//  Purpose  : Two-stage sprite-layer compositor for a VGA pixel stream.
//             Stage 1 picks the highest-priority visible, enabled,
//             non-transparent layer (or the background) and registers it
//             together with video_on. Stage 2 applies blanking, a
//             frame-counted white flash and a frame-stepped global
//             brightness fade, then drives the DAC register.
//  Ports    : clk, reset         - system clock, async active-high reset
//             pixel_tick         - pixel-rate enable for both pipe stages
//             video_on           - active display area
//             frame_start        - one-clk pulse per frame
//             layer_on/layer_en  - per-layer hit / enable (bit 0 = top)
//             layer_rgb, bg_rgb  - packed layer colours, background colour
//             flash_req          - start/restart a flash
//             fade_out_req/in    - start fading out / in
//             rgb                - registered output pixel
//             fade_level         - brightness 0..8
//             fade_busy          - a fade is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module layer_compositor #(
    parameter int                 NUM_LAYERS       = 8,
    parameter int                 COLOR_W          = 12,
    parameter logic [COLOR_W-1:0] KEY_COLOR        = 12'hF0F,
    parameter int                 FADE_STEP_FRAMES = 4,
    parameter int                 FLASH_FRAMES     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pixel_tick,
    input  logic                          video_on,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS-1:0]         layer_on,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [COLOR_W-1:0]            bg_rgb,
    input  logic                          flash_req,
    input  logic                          fade_out_req,
    input  logic                          fade_in_req,
    output logic [COLOR_W-1:0]            rgb,
    output logic [3:0]                    fade_level,
    output logic                          fade_busy
);

    localparam int c_CH_W = COLOR_W / 3;

    typedef enum logic [1:0] {
        ST_BRIGHT   = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_DARK     = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: layer selection
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] w_sel;
    logic               r_vid1;
    logic [COLOR_W-1:0] r_col1;

    // Walk from lowest priority upwards so the lowest visible index wins.
    always_comb begin
        w_sel = bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i] && layer_en[i] &&
                (layer_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR)) begin
                w_sel = layer_rgb[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vid1 <= 1'b0;
            r_col1 <= '0;
        end else if (pixel_tick) begin
            r_vid1 <= video_on;
            r_col1 <= w_sel;
        end
    end

    // ------------------------------------------------------------------
    // Flash counter: white on odd counts, so the first frame after a
    // request (count = FLASH_FRAMES, even by default) is normal.
    // ------------------------------------------------------------------
    logic [7:0] r_flash_cnt;
    logic       w_flash_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash_cnt <= 8'd0;
        end else if (flash_req) begin
            r_flash_cnt <= 8'(FLASH_FRAMES);
        end else if (frame_start && (r_flash_cnt != 8'd0)) begin
            r_flash_cnt <= r_flash_cnt - 8'd1;
        end
    end

    assign w_flash_on = (r_flash_cnt != 8'd0) && r_flash_cnt[0];

    // ------------------------------------------------------------------
    // Fade FSM
    // ------------------------------------------------------------------
    state_t     r_state, w_state_nx;
    logic [3:0] r_level, w_level_nx;
    logic [7:0] r_frame_cnt, w_frame_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_BRIGHT;
            r_level     <= 4'd8;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nx;
            r_level     <= w_level_nx;
            r_frame_cnt <= w_frame_nx;
        end
    end

    // The level step is resolved first; requests are then judged against
    // the post-step state, so a request landing on a step edge sees the
    // state the step produced.
    always_comb begin
        w_state_nx = r_state;
        w_level_nx = r_level;
        w_frame_nx = r_frame_cnt;

        if (((r_state == ST_FADE_OUT) || (r_state == ST_FADE_IN)) && frame_start) begin
            if (r_frame_cnt == 8'(FADE_STEP_FRAMES - 1)) begin
                w_frame_nx = 8'd0;
                if (r_state == ST_FADE_OUT) begin
                    if (r_level != 4'd0) begin
                        w_level_nx = r_level - 4'd1;
                    end
                    if (r_level <= 4'd1) begin
                        w_state_nx = ST_DARK;
                    end
                end else begin
                    if (r_level < 4'd8) begin
                        w_level_nx = r_level + 4'd1;
                    end
                    if (r_level >= 4'd7) begin
                        w_state_nx = ST_BRIGHT;
                    end
                end
            end else begin
                w_frame_nx = r_frame_cnt + 8'd1;
            end
        end

        // fade_out_req has priority: when it is high, fade_in_req is ignored
        // even if fade_out_req itself does not apply in the current state.
        if (fade_out_req) begin
            if ((w_state_nx == ST_BRIGHT) || (w_state_nx == ST_FADE_IN)) begin
                w_state_nx = ST_FADE_OUT;
                w_frame_nx = 8'd0;
            end
        end else if (fade_in_req) begin
            if ((w_state_nx == ST_DARK) || (w_state_nx == ST_FADE_OUT)) begin
                w_state_nx = ST_FADE_IN;
                w_frame_nx = 8'd0;
            end
        end
    end

    assign fade_level = r_level;
    assign fade_busy  = (r_state == ST_FADE_OUT) || (r_state == ST_FADE_IN);

    // ------------------------------------------------------------------
    // Stage 2: per-channel brightness scaling and output register
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] w_scaled;

    for (genvar k = 0; k < 3; k++) begin : g_chan
        logic [c_CH_W+3:0] w_prod;
        // ch * level fits in C+4 bits for level <= 8; divide by 8 afterwards.
        assign w_prod = {4'b0000, r_col1[k*c_CH_W +: c_CH_W]} *
                        {{c_CH_W{1'b0}}, r_level};
        assign w_scaled[k*c_CH_W +: c_CH_W] = c_CH_W'(w_prod >> 3);
    end

    // Any bits above 3*C (when COLOR_W is not a multiple of 3) stay zero.
    if (COLOR_W > 3 * c_CH_W) begin : g_pad
        assign w_scaled[COLOR_W-1:3*c_CH_W] = '0;
    end

    logic [COLOR_W-1:0] r_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
        end else if (pixel_tick) begin
            if (!r_vid1) begin
                r_rgb <= '0;
            end else if (w_flash_on) begin
                r_rgb <= '1;
            end else begin
                r_rgb <= w_scaled;
            end
        end
    end

    assign rgb = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_compositor
//  Purpose  : Self-checking bench for layer_compositor. A behavioural model
//             (pixel pipeline as two stored values, fade as level/direction/
//             frame count, flash as an integer countdown) is advanced on every
//             clock edge and compared against the DUT; directed sequences add
//             hand-computed literal expectations, followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

    localparam int          NL  = 8;
    localparam int          CW  = 12;
    localparam logic [11:0] KEY = 12'hF0F;
    localparam int          FSF = 4;
    localparam int          FF  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pixel_tick = 1'b0;
    logic          video_on = 1'b0;
    logic          frame_start = 1'b0;
    logic          flash_req = 1'b0;
    logic          fade_out_req = 1'b0;
    logic          fade_in_req = 1'b0;
    logic [NL-1:0] layer_on = '0;
    logic [NL-1:0] layer_en = '0;
    logic [NL*CW-1:0] layer_rgb = '0;
    logic [CW-1:0] bg_rgb = '0;
    logic [CW-1:0] rgb;
    logic [3:0]    fade_level;
    logic          fade_busy;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int          m_level, m_dir, m_fc, m_fcnt;
    logic        m_vid1;
    logic [11:0] m_col1, m_rgb;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS(NL), .COLOR_W(CW), .KEY_COLOR(KEY),
        .FADE_STEP_FRAMES(FSF), .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
        .frame_start(frame_start), .layer_on(layer_on), .layer_en(layer_en),
        .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .flash_req(flash_req),
        .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
        .rgb(rgb), .fade_level(fade_level), .fade_busy(fade_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pick(input logic [NL-1:0] on, input logic [NL-1:0] en,
                                         input logic [NL*CW-1:0] cols, input logic [11:0] bg);
        for (int i = 0; i < NL; i++) begin
            if (on[i] && en[i] && cols[i*CW +: CW] != KEY) return cols[i*CW +: CW];
        end
        return bg;
    endfunction

    function automatic logic [11:0] scale(input logic [11:0] c, input int lvl);
        int r, g, b;
        r = c[11:8]; g = c[7:4]; b = c[3:0];
        r = r * lvl / 8; g = g * lvl / 8; b = b * lvl / 8;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    task automatic model_reset();
        m_level = 8; m_dir = 0; m_fc = 0; m_fcnt = 0;
        m_vid1 = 1'b0; m_col1 = '0; m_rgb = '0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        if (pixel_tick) begin
            if (!m_vid1)              m_rgb = '0;
            else if (m_fcnt % 2 == 1) m_rgb = 12'hFFF;
            else                      m_rgb = scale(m_col1, m_level);
            m_vid1 = video_on;
            m_col1 = pick(layer_on, layer_en, layer_rgb, bg_rgb);
        end
        if (flash_req)                         m_fcnt = FF;
        else if (frame_start && m_fcnt > 0)    m_fcnt = m_fcnt - 1;
        if (m_dir != 0 && frame_start) begin
            m_fc++;
            if (m_fc == FSF) begin
                m_fc = 0;
                m_level += m_dir;
                if (m_level < 0) m_level = 0;
                if (m_level > 8) m_level = 8;
                if (m_level == 0 || m_level == 8) m_dir = 0;
            end
        end
        if (fade_out_req) begin
            if (m_dir == 1 || (m_dir == 0 && m_level == 8)) begin m_dir = -1; m_fc = 0; end
        end else if (fade_in_req) begin
            if (m_dir == -1 || (m_dir == 0 && m_level == 0)) begin m_dir = 1; m_fc = 0; end
        end
    endtask

    // One clock: edge, model update, compare, then drop the one-clk pulses.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("rgb", rgb, m_rgb);
        check("fade_level", fade_level, m_level);
        check("fade_busy", fade_busy, (m_dir != 0));
        frame_start = 0; flash_req = 0; fade_out_req = 0; fade_in_req = 0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1; step();
            step();
        end
    endtask

    // Asynchronous reset between edges; outputs must clear without any edge.
    task automatic async_reset();
        #2;
        reset = 1;
        #1;
        check("rst_rgb", rgb, 12'h000);
        check("rst_level", fade_level, 4'd8);
        check("rst_busy", fade_busy, 1'b0);
        model_reset();
        #1;
        reset = 0;
    endtask

    task automatic set_layer(input int i, input logic [11:0] c);
        layer_rgb[i*CW +: CW] = c;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", rgb, 12'h000);
        check("reset_level", fade_level, 4'd8);
        check("reset_busy", fade_busy, 1'b0);
        @(negedge clk);
        reset = 0;

        // priority and colour key
        pixel_tick = 1; video_on = 1; layer_en = '1; bg_rgb = 12'h123;
        layer_on = 8'b0000_0110; set_layer(1, 12'hF0F); set_layer(2, 12'h0A0);
        step(); step();
        check("prio_key", rgb, 12'h0A0);
        layer_en[2] = 1'b0;
        step(); step();
        check("disabled_bg", rgb, 12'h123);

        // blanking latency
        video_on = 0; step();
        check("blank_lat1", rgb, 12'h123);
        video_on = 1; step();
        check("blank_out", rgb, 12'h000);
        step();
        check("blank_end", rgb, 12'h123);

        // hold while pixel_tick is low
        pixel_tick = 0; video_on = 0; bg_rgb = 12'h456;
        step(); step(); step();
        check("hold", rgb, 12'h123);
        pixel_tick = 1; video_on = 1; bg_rgb = 12'h123;

        // fade out, reversal, darkness, both-requests, fade back in
        layer_on = 8'b0000_0001; set_layer(0, 12'hFFF);
        step(); step();
        check("bright_white", rgb, 12'hFFF);
        fade_out_req = 1; step();
        check("fo_busy", fade_busy, 1'b1);
        frames(4);
        check("fo_lvl7", fade_level, 4'd7);
        frames(8);
        check("fo_lvl5", fade_level, 4'd5);
        fade_in_req = 1; step();
        frames(3);
        check("fi_lvl5_hold", fade_level, 4'd5);
        frames(1);
        check("fi_lvl6", fade_level, 4'd6);
        fade_out_req = 1; step();
        frames(8);
        check("fo_lvl4", fade_level, 4'd4);
        step(); step();
        check("scaled_777", rgb, 12'h777);
        frames(16);
        check("dark_lvl", fade_level, 4'd0);
        check("dark_busy", fade_busy, 1'b0);
        check("dark_rgb", rgb, 12'h000);
        fade_out_req = 1; fade_in_req = 1; step();
        frames(4);
        check("both_ignored_lvl", fade_level, 4'd0);
        check("both_ignored_busy", fade_busy, 1'b0);
        fade_in_req = 1; step();
        frames(32);
        check("fi_bright_lvl", fade_level, 4'd8);
        check("fi_bright_busy", fade_busy, 1'b0);

        // flash
        set_layer(0, 12'h0A0);
        step(); step();
        flash_req = 1; step();
        step(); step();
        check("flash_cnt8", rgb, 12'h0A0);
        frame_start = 1; step();
        step();
        check("flash_cnt7", rgb, 12'hFFF);
        frames(1);
        check("flash_cnt6", rgb, 12'h0A0);
        frames(3);
        check("flash_cnt3", rgb, 12'hFFF);
        flash_req = 1; step();
        step();
        check("flash_reload", rgb, 12'h0A0);
        frames(8);
        check("flash_done", rgb, 12'h0A0);

        // reset mid-fade with flash running, pixel_tick low
        fade_out_req = 1; step();
        frames(20);
        check("pre_rst_lvl3", fade_level, 4'd3);
        flash_req = 1; step();
        frame_start = 1; step();
        pixel_tick = 0; step();
        async_reset();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            pixel_tick   = ($urandom_range(1) == 1);
            video_on     = ($urandom_range(7) != 0);
            frame_start  = ($urandom_range(5) == 0);
            flash_req    = ($urandom_range(79) == 0);
            fade_out_req = ($urandom_range(49) == 0);
            fade_in_req  = ($urandom_range(49) == 0);
            layer_on     = NL'($urandom);
            layer_en     = ($urandom_range(3) == 0) ? NL'($urandom) : '1;
            bg_rgb       = 12'($urandom);
            for (int i = 0; i < NL; i++) begin
                set_layer(i, ($urandom_range(3) == 0) ? KEY : 12'($urandom));
            end
            step();
            if ($urandom_range(699) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
